// File: rtl/csa_resolve_pipe.sv
// Pipelined carry-save resolver: SEG_W bits per stage, then drop/round/saturate; latency NSEG+1.
// One global advance enable holds every stage while the output is stalled; clr flushes all valid bits.
module csa_resolve_pipe #(
  parameter int IN_W  = 20,
  parameter int DROP  = 6,
  parameter int OUT_W = 14,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [IN_W-1:0]  in_carry,
  input  logic             rnd_en,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat
);

  localparam int NSEG = (IN_W + SEG_W - 1) / SEG_W;
  localparam int TW   = IN_W + 1 - DROP;
  localparam int RW   = TW + 1;

  logic             en;
  logic [IN_W-1:0]  a_q   [NSEG];
  logic [IN_W-1:0]  a_d   [NSEG];
  logic [IN_W-1:0]  b_q   [NSEG];
  logic [IN_W-1:0]  b_d   [NSEG];
  logic [IN_W:0]    r_q   [NSEG];
  logic [IN_W:0]    r_d   [NSEG];
  logic             c_q   [NSEG];
  logic             c_d   [NSEG];
  logic             vld_q [NSEG];
  logic             vld_d [NSEG];
  logic             rnd_q [NSEG];
  logic             rnd_d [NSEG];
  logic             sat_q [NSEG];
  logic             sat_d [NSEG];
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [OUT_W-1:0] out_data_d;
  logic             out_sat_q;
  logic             out_sat_d;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO   = k * SEG_W;
    localparam int W    = (IN_W - LO < SEG_W) ? (IN_W - LO) : SEG_W;
    localparam bit LAST = (k == NSEG - 1);

    logic [IN_W-1:0] a_in;
    logic [IN_W-1:0] b_in;
    logic [IN_W:0]   r_in;
    logic            c_in;
    logic [W:0]      seg_s;
    logic [IN_W:0]   r_nx;

    if (k == 0) begin : g_first
      assign a_in     = in_sum;
      assign b_in     = in_carry;
      assign r_in     = '0;
      assign c_in     = 1'b0;
      assign vld_d[k] = in_valid;
      assign rnd_d[k] = rnd_en;
      assign sat_d[k] = sat_en;
    end else begin : g_next
      assign a_in     = a_q[k-1];
      assign b_in     = b_q[k-1];
      assign r_in     = r_q[k-1];
      assign c_in     = c_q[k-1];
      assign vld_d[k] = vld_q[k-1];
      assign rnd_d[k] = rnd_q[k-1];
      assign sat_d[k] = sat_q[k-1];
    end

    assign seg_s = {1'b0, a_in[LO +: W]} + {1'b0, b_in[LO +: W]} + (W+1)'(c_in);

    // The last segment's carry-out is bit IN_W of the full sum.
    always_comb begin
      r_nx            = r_in;
      r_nx[LO +: W]   = seg_s[W-1:0];
      if (LAST) begin
        r_nx[IN_W]    = seg_s[W];
      end
    end

    assign a_d[k] = a_in;
    assign b_d[k] = b_in;
    assign r_d[k] = r_nx;
    assign c_d[k] = seg_s[W];
  end

  logic [IN_W:0]  s_full;
  logic [TW-1:0]  t_val;
  logic [RW-1:0]  r_val;
  logic           ovf;

  assign s_full = r_q[NSEG-1];
  assign t_val  = s_full[IN_W:DROP];
  assign r_val  = {1'b0, t_val} + RW'(rnd_q[NSEG-1] & s_full[DROP-1]);
  // RW is always wider than OUT_W, so the overflow slice is never empty.
  assign ovf    = sat_q[NSEG-1] & (|r_val[RW-1:OUT_W]);

  always_comb begin
    out_data_d = r_val[OUT_W-1:0];
    out_sat_d  = 1'b0;
    if (ovf) begin
      out_data_d = '1;
      out_sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        vld_q[k] <= 1'b0;
        rnd_q[k] <= 1'b0;
        sat_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      if (en) begin
        for (int k = 0; k < NSEG; k++) begin
          a_q[k]   <= a_d[k];
          b_q[k]   <= b_d[k];
          r_q[k]   <= r_d[k];
          c_q[k]   <= c_d[k];
          vld_q[k] <= vld_d[k];
          rnd_q[k] <= rnd_d[k];
          sat_q[k] <= sat_d[k];
        end
        out_valid_q <= vld_q[NSEG-1];
        out_data_q  <= out_data_d;
        out_sat_q   <= out_sat_d;
      end
      // Flush wins over both advance and hold.
      if (clr) begin
        for (int k = 0; k < NSEG; k++) begin
          vld_q[k] <= 1'b0;
        end
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Scoreboard bench for csa_resolve_pipe in three parameter sets; directed cases run on set 0.
// Expected results come from plain wide arithmetic on (sum + carry), independent of the segment pipeline.
module tb_csa_resolve_pipe;

  localparam int NCFG  = 3;
  localparam int NBEAT = 10000;
  localparam int LIMIT = 85000;

  typedef struct {
    logic [63:0] data;
    logic        sat;
    int          acc;
    int          stl;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic        rst_a       [NCFG];
  logic        clr_a       [NCFG];
  logic        in_valid_a  [NCFG];
  logic        rnd_a       [NCFG];
  logic        sat_a       [NCFG];
  logic        out_ready_a [NCFG];
  logic [63:0] sum_a       [NCFG];
  logic [63:0] carry_a     [NCFG];
  wire         in_ready_a  [NCFG];
  wire         out_valid_a [NCFG];
  wire         out_sat_a   [NCFG];
  wire  [63:0] out_data_a  [NCFG];
  bit          go          [NCFG];
  bit          done        [NCFG];
  int          pend        [NCFG];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-width sum, shift, optional half-up, then clip or wrap.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input int drop,
                                input int ow, input logic rnd, input logic sat,
                                output logic [63:0] d, output logic s);
    logic [63:0] sm, t, rr, mx;
    sm = a + b;
    t  = sm >> drop;
    rr = t + ((rnd && sm[drop-1]) ? 64'd1 : 64'd0);
    mx = (64'd1 << ow) - 64'd1;
    if (sat && rr > mx) begin
      d = mx;
      s = 1'b1;
    end else begin
      d = rr & mx;
      s = 1'b0;
    end
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int IW = (g == 0) ? 20 : (g == 1) ? 32 : 16;
    localparam int DR = (g == 0) ? 6  : (g == 1) ? 8  : 4;
    localparam int OW = (g == 0) ? 14 : (g == 1) ? 16 : 13;
    localparam int SG = (g == 0) ? 8  : (g == 1) ? 5  : 16;
    localparam int NS = (IW + SG - 1) / SG;
    localparam logic [63:0] MASK = (64'd1 << IW) - 64'd1;

    logic [OW-1:0] od;

    csa_resolve_pipe #(.IN_W(IW), .DROP(DR), .OUT_W(OW), .SEG_W(SG)) u_dut (
      .clk       (clk),
      .reset     (rst_a[g]),
      .clr       (clr_a[g]),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_sum    (sum_a[g][IW-1:0]),
      .in_carry  (carry_a[g][IW-1:0]),
      .rnd_en    (rnd_a[g]),
      .sat_en    (sat_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
      .out_data  (od),
      .out_sat   (out_sat_a[g])
    );
    assign out_data_a[g] = 64'(od);

    exp_t        q[$];
    logic        shown      = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_clr   = 1'b0;
    logic [63:0] prev_d     = '0;
    logic        prev_s     = 1'b0;
    int          stall_cnt  = 0;

    always @(negedge clk) begin
      exp_t e;
      if (rst_a[g]) begin
        q.delete();
        shown      = 1'b0;
        prev_stall = 1'b0;
        prev_clr   = 1'b0;
      end else begin
        if (prev_stall && !prev_clr) begin
          check($sformatf("cfg%0d hold valid", g), out_valid_a[g], 1);
          check($sformatf("cfg%0d hold data", g), out_data_a[g], prev_d);
          check($sformatf("cfg%0d hold sat", g), out_sat_a[g], prev_s);
        end
        if (out_valid_a[g]) begin
          if (q.size() == 0) begin
            check($sformatf("cfg%0d spurious out_valid", g), out_valid_a[g], 0);
          end else begin
            if (!shown) begin
              check($sformatf("cfg%0d latency", g),
                    64'(cyc - q[0].acc - (stall_cnt - q[0].stl)), 64'(NS + 1));
              shown = 1'b1;
            end
            if (out_ready_a[g]) begin
              e = q.pop_front();
              check($sformatf("cfg%0d data", g), out_data_a[g], e.data);
              check($sformatf("cfg%0d sat", g), out_sat_a[g], e.sat);
              shown = 1'b0;
            end
          end
        end
        prev_stall = out_valid_a[g] && !out_ready_a[g];
        prev_d     = out_data_a[g];
        prev_s     = out_sat_a[g];
        prev_clr   = clr_a[g];
        if (prev_stall) stall_cnt++;
        if (clr_a[g]) begin
          q.delete();
          shown = 1'b0;
        end else if (in_valid_a[g] && in_ready_a[g]) begin
          model(sum_a[g], carry_a[g], DR, OW, rnd_a[g], sat_a[g], e.data, e.sat);
          e.acc = cyc;
          e.stl = stall_cnt;
          q.push_back(e);
        end
      end
      pend[g] = q.size();
    end

    initial begin
      int acc_n;
      acc_n = 0;
      wait (go[g]);
      while (acc_n < NBEAT && cyc < LIMIT) begin
        @(posedge clk); #1;
        in_valid_a[g] = ($urandom_range(3) != 0);
        if ($urandom_range(7) == 0) begin
          sum_a[g]   = MASK;
          carry_a[g] = MASK;
        end else begin
          sum_a[g]   = {$urandom, $urandom} & MASK;
          carry_a[g] = {$urandom, $urandom} & MASK;
        end
        rnd_a[g]       = 1'($urandom_range(1));
        sat_a[g]       = 1'($urandom_range(1));
        out_ready_a[g] = ($urandom_range(3) != 0);
        clr_a[g]       = ($urandom_range(999) == 0);
        @(negedge clk);
        if (in_valid_a[g] && in_ready_a[g] && !clr_a[g]) acc_n++;
      end
      check($sformatf("cfg%0d beats accepted", g), 64'(acc_n), 64'(NBEAT));
      @(posedge clk); #1;
      in_valid_a[g]  = 1'b0;
      clr_a[g]       = 1'b0;
      out_ready_a[g] = 1'b1;
      repeat (NS + 6) @(posedge clk);
      done[g] = 1'b1;
    end
  end

  task automatic one_beat(input string name, input logic [63:0] s, input logic [63:0] c,
                          input logic r, input logic st, input logic [63:0] ed, input logic es);
    int t0, n;
    @(posedge clk); #1;
    in_valid_a[0]  = 1'b1;
    sum_a[0]       = s;
    carry_a[0]     = c;
    rnd_a[0]       = r;
    sat_a[0]       = st;
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    t0 = cyc;
    check({name, " accept"}, in_ready_a[0], 1);
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_a[0] && n < 20);
    check({name, " latency"}, 64'(cyc - t0), 4);
    check({name, " data"}, out_data_a[0], ed);
    check({name, " sat"}, out_sat_a[0], es);
  endtask

  task automatic backpressure();
    int  sent;
    bit  acc;
    sent = 0;
    acc  = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      if (acc) begin
        sum_a[0]   = 64'($urandom_range(20'hFFFFF));
        carry_a[0] = 64'($urandom_range(20'hFFFFF));
        rnd_a[0]   = 1'($urandom_range(1));
        sat_a[0]   = 1'($urandom_range(1));
      end
      in_valid_a[0]  = (sent < 8);
      out_ready_a[0] = !(i >= 5 && i <= 7);
      @(negedge clk);
      if (i >= 5 && i <= 7) check($sformatf("bp in_ready c%0d", i), in_ready_a[0], 0);
      acc = in_valid_a[0] && in_ready_a[0];
      if (acc) sent++;
    end
    in_valid_a[0]  = 1'b0;
    out_ready_a[0] = 1'b1;
    check("bp beats sent", 64'(sent), 8);
    check("bp pending", 64'(pend[0]), 0);
  endtask

  task automatic flush_test();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      in_valid_a[0]  = 1'b1;
      sum_a[0]       = 64'($urandom_range(20'hFFFFF));
      carry_a[0]     = 64'($urandom_range(20'hFFFFF));
      clr_a[0]       = (i == 3);
      out_ready_a[0] = 1'b1;
    end
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    clr_a[0]      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("flush out_valid +%0d", i), out_valid_a[0], 0);
    end
    check("flush pending", 64'(pend[0]), 0);
    one_beat("post-flush", 64'h00040, 64'h00040, 1'b0, 1'b0, 64'h0002, 1'b0);
  endtask

  task automatic reset_test();
    int n;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid_a[0]  = 1'b1;
      sum_a[0]       = 64'hFFFFF;
      carry_a[0]     = 64'h0;
      rnd_a[0]       = 1'b0;
      sat_a[0]       = 1'b0;
      out_ready_a[0] = 1'b0;
    end
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid_a[0] && n < 20);
    check("pre-reset out_valid", out_valid_a[0], 1);
    check("pre-reset data", out_data_a[0], 64'h3FFF);
    #3;
    rst_a[0] = 1'b1;
    #1;
    check("async reset out_valid", out_valid_a[0], 0);
    check("async reset data", out_data_a[0], 0);
    check("async reset sat", out_sat_a[0], 0);
    @(negedge clk);
    @(posedge clk); #2;
    rst_a[0] = 1'b0;
    #1;
    check("post-reset in_ready", in_ready_a[0], 1);
    out_ready_a[0] = 1'b1;
    one_beat("post-reset", 64'h00020, 64'h00000, 1'b1, 1'b0, 64'h0001, 1'b0);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete within the cycle limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NCFG; i++) begin
      rst_a[i]       = 1'b1;
      clr_a[i]       = 1'b0;
      in_valid_a[i]  = 1'b0;
      rnd_a[i]       = 1'b0;
      sat_a[i]       = 1'b0;
      out_ready_a[i] = 1'b1;
      sum_a[i]       = '0;
      carry_a[i]     = '0;
      go[i]          = 1'b0;
      done[i]        = 1'b0;
      pend[i]        = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid_a[0], 0);
    check("reset out_data", out_data_a[0], 0);
    check("reset out_sat", out_sat_a[0], 0);
    for (int i = 0; i < NCFG; i++) rst_a[i] = 1'b0;
    #1;
    check("reset in_ready", in_ready_a[0], 1);
    go[1] = 1'b1;
    go[2] = 1'b1;

    one_beat("basic",        64'h00040, 64'h00040, 1'b0, 1'b0, 64'h0002, 1'b0);
    one_beat("round up",     64'h00020, 64'h00000, 1'b1, 1'b0, 64'h0001, 1'b0);
    one_beat("round off",    64'h00020, 64'h00000, 1'b0, 1'b0, 64'h0000, 1'b0);
    one_beat("carry r0",     64'h0003F, 64'h00001, 1'b0, 1'b0, 64'h0001, 1'b0);
    one_beat("carry r1",     64'h0003F, 64'h00001, 1'b1, 1'b0, 64'h0001, 1'b0);
    one_beat("saturate",     64'h80000, 64'h80000, 1'b0, 1'b1, 64'h3FFF, 1'b1);
    one_beat("wrap",         64'h80000, 64'h80000, 1'b0, 1'b0, 64'h0000, 1'b0);
    one_beat("rnd sat ones", 64'hFFFFF, 64'hFFFFF, 1'b1, 1'b1, 64'h3FFF, 1'b1);
    backpressure();
    flush_test();
    reset_test();
    go[0] = 1'b1;

    wait (done[0] && done[1] && done[2]);
    for (int i = 0; i < NCFG; i++) check($sformatf("cfg%0d drained", i), 64'(pend[i]), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
